// File: rtl/string_hw_pkg.sv
// Shared types and register map for the string compare accelerator.
// Holds FSM states, compare codes, register addresses and bit positions.
package string_hw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMP_EQ  = 2'b00,
        CMP_LT  = 2'b01,
        CMP_GT  = 2'b10,
        CMP_ERR = 2'b11
    } cmp_t;

    localparam logic [2:0] ADDR_A      = 3'd0;
    localparam logic [2:0] ADDR_B      = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_RESULT = 3'd3;

    localparam int CTRL_GO      = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_LEN_LSB = 8;

    localparam int ST_DONE      = 0;
    localparam int ST_BUSY      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_ERR       = 3;
    localparam int ST_IRQ_EN    = 4;
    localparam int ST_CNT_A_LSB = 8;
    localparam int ST_CNT_B_LSB = 16;

    localparam int RES_CMP_LSB  = 0;
    localparam int RES_IDX_LSB  = 8;

endpackage

// File: rtl/string_word_buffer.sv
// Word buffer for one string: append-only push at count, byte readout.
// Ports: push_i/allow_i/clear_i/data_i in; ptr_i byte index; count_o, ovf_o, byte_o out.
module string_word_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1,
    parameter int PTR_W  = $clog2(DEPTH * DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              allow_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              ovf_o,
    output logic [7:0]        byte_o
);
    localparam int BPW    = DATA_W / 8;
    localparam int LANE_W = $clog2(BPW);
    localparam int IDX_W  = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              accept;
    logic [DATA_W-1:0] word;
    logic [LANE_W-1:0] lane;

    assign accept = push_i && allow_i && !clear_i
                    && (count_q < CNT_W'(DEPTH));

    // A rejected push (busy or full) is dropped and flagged sticky.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            count_d = count_q + CNT_W'(1);
        end else if (push_i) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[count_q[IDX_W-1:0]] <= data_i;
        end
    end

    // Byte 0 of a word sits in the most significant lane.
    assign word = mem_q[ptr_i[PTR_W-1:LANE_W]];
    assign lane = ptr_i[LANE_W-1:0];

    always_comb begin
        byte_o = '0;
        for (int l = 0; l < BPW; l++) begin
            if (lane == LANE_W'(l)) begin
                byte_o = word[DATA_W-1-8*l -: 8];
            end
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/string_cmp_sequencer.sv
// Avalon-MM string compare accelerator: buffers A/B, byte-serial compare.
// Ports: clk, reset_n, chipselect, address, write, read, writedata, readdata, irq.
module string_cmp_sequencer
    import string_hw_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [2:0]        address,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);
    localparam int BPW   = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH * BPW);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    cmp_t              cmp_q, cmp_d;
    logic              err_q, err_d;
    logic              irq_en_q, irq_en_d;
    logic [DATA_W-1:0] readdata_q, rdata;

    logic              wr_en, rd_en, wr_a, wr_b, wr_ctrl;
    logic              go, clr, allow, last, done, busy;
    logic [LEN_W-1:0]  len_w;
    logic [CNT_W-1:0]  count_a, count_b, min_cnt;
    logic [LEN_W:0]    cap;
    logic              ovf_a, ovf_b;
    logic [7:0]        byte_a, byte_b;

    assign wr_en   = chipselect & write;
    assign rd_en   = chipselect & read & ~write;
    assign wr_a    = wr_en && (address == ADDR_A);
    assign wr_b    = wr_en && (address == ADDR_B);
    assign wr_ctrl = wr_en && (address == ADDR_CTRL);

    // Clear wins over go in the same control write.
    assign clr   = wr_ctrl & writedata[CTRL_CLEAR];
    assign go    = wr_ctrl & writedata[CTRL_GO] & ~writedata[CTRL_CLEAR];
    assign len_w = writedata[CTRL_LEN_LSB +: LEN_W];
    assign allow = (state_q != RUN);
    assign done  = (state_q == DONE);
    assign busy  = (state_q == RUN);

    assign min_cnt = (count_a < count_b) ? count_a : count_b;
    assign cap     = (LEN_W+1)'(min_cnt) * (LEN_W+1)'(BPW);
    assign last    = (LEN_W'(ptr_q) == len_q - LEN_W'(1));

    string_word_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .PTR_W  (PTR_W)
    ) u_buf_a (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (wr_a),
        .allow_i (allow),
        .clear_i (clr),
        .data_i  (writedata),
        .ptr_i   (ptr_q),
        .count_o (count_a),
        .ovf_o   (ovf_a),
        .byte_o  (byte_a)
    );

    string_word_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .PTR_W  (PTR_W)
    ) u_buf_b (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (wr_b),
        .allow_i (allow),
        .clear_i (clr),
        .data_i  (writedata),
        .ptr_i   (ptr_q),
        .count_o (count_b),
        .ovf_o   (ovf_b),
        .byte_o  (byte_b)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        idx_d    = idx_q;
        cmp_d    = cmp_q;
        err_d    = err_q;
        irq_en_d = wr_ctrl ? writedata[CTRL_IRQ_EN] : irq_en_q;

        if (clr) begin
            state_d = IDLE;
            ptr_d   = '0;
            idx_d   = '0;
            cmp_d   = CMP_EQ;
            err_d   = 1'b0;
        end else if (go && allow) begin
            len_d = len_w;
            ptr_d = '0;
            if ({1'b0, len_w} > cap) begin
                state_d = DONE;
                err_d   = 1'b1;
                cmp_d   = CMP_ERR;
                idx_d   = '0;
            end else if (len_w == '0) begin
                state_d = DONE;
                err_d   = 1'b0;
                cmp_d   = CMP_EQ;
                idx_d   = '0;
            end else begin
                state_d = RUN;
                err_d   = 1'b0;
            end
        end else if (state_q == RUN) begin
            if (byte_a != byte_b) begin
                state_d = DONE;
                cmp_d   = (byte_a < byte_b) ? CMP_LT : CMP_GT;
                idx_d   = LEN_W'(ptr_q);
            end else if (byte_a == 8'h00) begin
                state_d = DONE;
                cmp_d   = CMP_EQ;
                idx_d   = LEN_W'(ptr_q);
            end else if (last) begin
                state_d = DONE;
                cmp_d   = CMP_EQ;
                idx_d   = len_q;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            cmp_q    <= CMP_EQ;
            err_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            cmp_q    <= cmp_d;
            err_q    <= err_d;
            irq_en_q <= irq_en_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (address)
            ADDR_A: rdata = DATA_W'(count_a);
            ADDR_B: rdata = DATA_W'(count_b);
            ADDR_CTRL: begin
                rdata[ST_DONE]                 = done;
                rdata[ST_BUSY]                 = busy;
                rdata[ST_OVF]                  = ovf_a | ovf_b;
                rdata[ST_ERR]                  = err_q;
                rdata[ST_IRQ_EN]               = irq_en_q;
                rdata[ST_CNT_A_LSB +: CNT_W]   = count_a;
                rdata[ST_CNT_B_LSB +: CNT_W]   = count_b;
            end
            ADDR_RESULT: begin
                rdata[RES_CMP_LSB +: 2]     = cmp_q;
                rdata[RES_IDX_LSB +: LEN_W] = idx_q;
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            readdata_q <= rdata;
        end
    end

    assign readdata = readdata_q;
    assign irq      = done & irq_en_q;

endmodule

// File: tb/tb_string_cmp_sequencer.sv
// Self-checking bench: directed cases plus random traffic vs a behavioural model.
// Model predicts each go's outcome and completion cycle from the string bytes.
module tb_string_cmp_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic [2:0]  address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    logic [31:0] rd_last;

    // behavioural model
    logic [31:0] aw [16];
    logic [31:0] bw [16];
    int          ca = 0, cb = 0;
    bit          movf = 0, mirqen = 0, merr = 0, going = 0;
    int          fin = 0;
    logic [1:0]  ocmp = 0, ncmp = 0;
    logic [6:0]  oidx = 0, nidx = 0;

    string_cmp_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write      (write),
        .read       (read),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic bit busy_at(int c);
        return going && (c < fin);
    endfunction

    function automatic bit done_at(int c);
        return going && (c >= fin);
    endfunction

    function automatic logic [31:0] result_at(int c);
        if (done_at(c)) return {17'b0, nidx, 6'b0, ncmp};
        return {17'b0, oidx, 6'b0, ocmp};
    endfunction

    function automatic logic [31:0] status_at(int c);
        logic [31:0] s;
        s = '0;
        s[0] = done_at(c);
        s[1] = busy_at(c);
        s[2] = movf;
        s[3] = merr;
        s[4] = mirqen;
        s[12:8] = 5'(ca);
        s[20:16] = 5'(cb);
        return s;
    endfunction

    function automatic logic [31:0] reg_exp(logic [2:0] a, int c);
        case (a)
            3'd0: return 32'(ca);
            3'd1: return 32'(cb);
            3'd2: return status_at(c);
            3'd3: return result_at(c);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] mbyte(bit isb, int i);
        logic [31:0] w;
        w = isb ? bw[i/4] : aw[i/4];
        return w[31-8*(i%4) -: 8];
    endfunction

    // Outcome of comparing the first len bytes; k is the deciding byte.
    task automatic cmp_model(input int len, output logic [1:0] cm,
                             output int ix, output int k);
        logic [7:0] a, b;
        cm = 2'b00;
        ix = len;
        k = len - 1;
        for (int i = 0; i < len; i++) begin
            a = mbyte(0, i);
            b = mbyte(1, i);
            if (a != b) begin
                cm = (a < b) ? 2'b01 : 2'b10;
                ix = i;
                k = i;
                return;
            end
            if (a == 8'h00) begin
                ix = i;
                k = i;
                return;
            end
        end
    endtask

    task automatic model_write(input logic [2:0] a, input logic [31:0] d,
                               input int p);
        int c, len, cap, ix, k;
        logic [31:0] r;
        logic [1:0] cm;
        c = p - 1;
        if (a == 3'd0) begin
            if (!busy_at(c) && ca < 16) begin aw[ca] = d; ca++; end
            else movf = 1;
        end else if (a == 3'd1) begin
            if (!busy_at(c) && cb < 16) begin bw[cb] = d; cb++; end
            else movf = 1;
        end else if (a == 3'd2) begin
            mirqen = d[2];
            if (d[1]) begin
                ca = 0; cb = 0; movf = 0; merr = 0; going = 0;
                ocmp = 0; oidx = 0;
            end else if (d[0] && !busy_at(c)) begin
                r = result_at(c);
                ocmp = r[1:0];
                oidx = r[14:8];
                len = int'(d[14:8]);
                cap = 4 * ((ca < cb) ? ca : cb);
                if (len > cap) begin
                    merr = 1; ncmp = 2'b11; nidx = 0; fin = p;
                end else if (len == 0) begin
                    merr = 0; ncmp = 2'b00; nidx = 0; fin = p;
                end else begin
                    merr = 0;
                    cmp_model(len, cm, ix, k);
                    ncmp = cm;
                    nidx = ix[6:0];
                    fin = p + 1 + k;
                end
                going = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && cmp_en)
            check("irq", {31'b0, irq}, {31'b0, done_at(cyc) & mirqen});
    end

    task automatic bus(input bit w, input bit r, input logic [2:0] a,
                       input logic [31:0] d);
        int p;
        logic [31:0] exp;
        @(negedge clk);
        chipselect = 1; write = w; read = r; address = a; writedata = d;
        exp = reg_exp(a, cyc);
        @(posedge clk);
        #1;
        p = cyc;
        chipselect = 0; write = 0; read = 0;
        if (w) model_write(a, d, p);
        else if (r) begin
            rd_last = readdata;
            check("read", readdata, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus(1, 0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        bus(0, 1, a, 32'h0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        ca = 0; cb = 0; movf = 0; mirqen = 0; merr = 0; going = 0;
        ocmp = 0; oidx = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int r;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 15);
            w[8*i +: 8] = (r == 0) ? 8'h00 : 8'h41 + 8'(r % 4);
        end
        return w;
    endfunction

    initial begin
        logic [31:0] w, first;
        int op, len, mn;

        do_reset();
        cmp_en = 1;
        rd(3'd2);
        check("reset_status", rd_last, 32'h0);

        // "HELLO" NUL-terminated in both buffers, irq disabled
        wr(3'd0, 32'h48454C4C); wr(3'd0, 32'h4F000000);
        wr(3'd1, 32'h48454C4C); wr(3'd1, 32'h4F000000);
        wr(3'd2, 32'h00000801);
        wait_cyc(4);
        rd(3'd2);
        check("hello_busy", rd_last, 32'h00020202);
        rd(3'd2);
        rd(3'd2);
        check("hello_done", rd_last, 32'h00020201);
        rd(3'd3);
        check("hello_result", rd_last, 32'h00000500);
        check("hello_irq", {31'b0, irq}, 32'h0);

        // "ABCD" vs "ABDD" with irq enabled
        wr(3'd2, 32'h2);
        wr(3'd0, 32'h41424344);
        wr(3'd1, 32'h41424444);
        wr(3'd2, 32'h00000405);
        wait_cyc(2);
        check("lt_irq_before", {31'b0, irq}, 32'h0);
        wait_cyc(1);
        check("lt_irq_rise", {31'b0, irq}, 32'h1);
        rd(3'd3);
        check("lt_result", rd_last, 32'h00000201);

        // overflow on the 17th push
        wr(3'd2, 32'h2);
        for (int i = 0; i < 17; i++) wr(3'd0, 32'h11111111 * i);
        rd(3'd0);
        check("ovf_count", rd_last, 32'd16);
        rd(3'd2);
        check("ovf_status", rd_last, 32'h00001004);
        wr(3'd2, 32'h2);
        rd(3'd2);
        check("clear_status", rd_last, 32'h0);

        // length beyond stored data
        wr(3'd0, 32'h41414141); wr(3'd0, 32'h42424242);
        wr(3'd1, 32'h41414141); wr(3'd1, 32'h42424242);
        wr(3'd1, 32'h43434343);
        wr(3'd2, 32'h00000C01);
        rd(3'd2);
        check("err_status", rd_last, 32'h00030209);
        rd(3'd3);
        check("err_result", rd_last, 32'h00000003);

        // mid-run ignored go, then clear
        wr(3'd2, 32'h2);
        for (int i = 0; i < 16; i++) begin
            wr(3'd0, 32'h41414141 + i);
            wr(3'd1, 32'h41414141 + i);
        end
        wr(3'd2, 32'h00004001);
        wr(3'd2, 32'h00000401);
        rd(3'd2);
        check("run_busy", rd_last, 32'h00101002);
        wait_cyc(7);
        wr(3'd2, 32'h2);
        rd(3'd2);
        check("run_clear", rd_last, 32'h0);

        // mid-run reset
        for (int i = 0; i < 16; i++) begin
            wr(3'd0, 32'h41414141 + i);
            wr(3'd1, 32'h41414141 + i);
        end
        wr(3'd2, 32'h00004005);
        wait_cyc(9);
        do_reset();
        rd(3'd2);
        check("rst_status", rd_last, 32'h0);
        rd(3'd3);
        check("rst_result", rd_last, 32'h0);

        // zero length, then repeated go on the same data
        wr(3'd0, 32'h41424344);
        wr(3'd1, 32'h41424344);
        wr(3'd2, 32'h00000001);
        rd(3'd2);
        check("len0_status", rd_last, 32'h00010101);
        rd(3'd3);
        check("len0_result", rd_last, 32'h0);
        wr(3'd2, 32'h00000401);
        wait_cyc(6);
        rd(3'd3);
        first = rd_last;
        check("len4_result", rd_last, 32'h00000400);
        wr(3'd2, 32'h00000401);
        wait_cyc(6);
        rd(3'd3);
        check("len4_repeat", rd_last, first);

        // random traffic
        for (int it = 0; it < 600; it++) begin
            op = $urandom_range(0, 19);
            if (op <= 2) begin
                wr(3'd0, rand_word());
            end else if (op <= 5) begin
                w = (cb < ca && $urandom_range(0, 3) != 0) ? aw[cb] : rand_word();
                if ($urandom_range(0, 7) == 0) w[7:0] = w[7:0] ^ 8'h01;
                wr(3'd1, w);
            end else if (op <= 8) begin
                mn = (ca < cb) ? ca : cb;
                len = $urandom_range(0, 4 * mn + 3);
                w = '0;
                w[14:8] = 7'(len);
                w[2] = 1'($urandom_range(0, 1));
                w[0] = 1'b1;
                wr(3'd2, w);
            end else if (op <= 11) begin
                rd(3'($urandom_range(0, 7)));
            end else if (op == 12) begin
                if ($urandom_range(0, 2) == 0) wr(3'd2, 32'h2);
            end else if (op == 13) begin
                w = '0;
                w[2] = 1'($urandom_range(0, 1));
                wr(3'd2, w);
            end else if (op == 14) begin
                wr(3'($urandom_range(3, 7)), $urandom());
            end else begin
                wait_cyc($urandom_range(1, 12));
            end
        end
        wait_cyc(80);
        rd(3'd2);
        rd(3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
